bmp_stream_writer: RTL and testbench

Downstream sink for the image reader stage. Converts the two-pixel-per-cycle RGB stream (VSYNC/HSYNC/D_R0..D_B1) into a byte-exact 24-bit BMP file stream, emitted as 48-bit little-endian words (6 file bytes per word). The block prepends a 54-byte BMP header (9 words), buffers pixels in a FIFO, and presents everything on a valid/ready output toward a file-dump or DMA sink.

---
 rtl/bmp_pkg.sv | 64 ++++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/bmp_stream_writer.sv | 136 +++++++++++++
 tb/tb_bmp_stream_writer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP stream writer: FSM encoding, header layout
// and the elaboration-time generator for the 54-byte BMP file header.
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int HDR_WORDS     = 9;

    // Byte offsets of the little-endian header fields
    localparam int OFS_SIGNATURE   = 0;
    localparam int OFS_FILE_SIZE   = 2;
    localparam int OFS_RESERVED    = 6;
    localparam int OFS_DATA_OFFSET = 10;
    localparam int OFS_DIB_SIZE    = 14;
    localparam int OFS_WIDTH       = 18;
    localparam int OFS_HEIGHT      = 22;
    localparam int OFS_PLANES      = 26;
    localparam int OFS_BPP         = 28;
    localparam int OFS_COMPRESSION = 30;
    localparam int OFS_IMAGE_SIZE  = 34;
    localparam int OFS_XPPM        = 38;
    localparam int OFS_YPPM        = 42;
    localparam int OFS_COLORS      = 46;
    localparam int OFS_IMPORTANT   = 50;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

    function automatic logic [BMP_HDR_BYTES*8-1:0] bmp_header_bits(input int w, input int h);
        logic [BMP_HDR_BYTES*8-1:0] hdr;
        logic [31:0]                imgSize;
        imgSize = w * h * 3;
        hdr = '0;
        hdr[OFS_SIGNATURE*8   +: 16] = 16'h4D42;
        hdr[OFS_FILE_SIZE*8   +: 32] = imgSize + BMP_HDR_BYTES;
        hdr[OFS_RESERVED*8    +: 32] = 32'd0;
        hdr[OFS_DATA_OFFSET*8 +: 32] = BMP_HDR_BYTES;
        hdr[OFS_DIB_SIZE*8    +: 32] = 32'd40;
        hdr[OFS_WIDTH*8       +: 32] = w;
        // Negative height marks the image as top-down, matching upstream row order
        hdr[OFS_HEIGHT*8      +: 32] = -h;
        hdr[OFS_PLANES*8      +: 16] = 16'd1;
        hdr[OFS_BPP*8         +: 16] = 16'd24;
        hdr[OFS_COMPRESSION*8 +: 32] = 32'd0;
        hdr[OFS_IMAGE_SIZE*8  +: 32] = imgSize;
        hdr[OFS_XPPM*8        +: 32] = 32'd2835;
        hdr[OFS_YPPM*8        +: 32] = 32'd2835;
        hdr[OFS_COLORS*8      +: 32] = 32'd0;
        hdr[OFS_IMPORTANT*8   +: 32] = 32'd0;
        return hdr;
    endfunction

    function automatic logic [47:0] bmp_header_word(input int idx, input int w, input int h);
        logic [BMP_HDR_BYTES*8-1:0] hdr;
        hdr = bmp_header_bits(w, h);
        if (idx < 0 || idx >= HDR_WORDS) begin
            return '0;
        end
        return hdr[idx*48 +: 48];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_data whenever
// the FIFO is not empty. A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 512
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_data   = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Storage has no reset; the pointers alone define which entries are live
    always_ff @(posedge HCLK) begin
        if (w_doPush && !i_clear) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// Converts a two-pixel-per-cycle RGB stream into a 24-bit BMP file stream of
// 48-bit little-endian words: 9 header words followed by one word per pixel pair.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 512
) (
    input  logic        HRESETn,
    input  logic        HCLK,
    input  logic        VSYNC,
    input  logic        HSYNC,
    input  logic [7:0]  D_R0,
    input  logic [7:0]  D_G0,
    input  logic [7:0]  D_B0,
    input  logic [7:0]  D_R1,
    input  logic [7:0]  D_G1,
    input  logic [7:0]  D_B1,
    output logic [47:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        frame_done,
    output logic        overflow,
    output logic        frame_err
);

    localparam logic [31:0] TOTAL_PAIRS = 32'(WIDTH * HEIGHT / 2);

    state_t      r_state;
    state_t      w_nextState;
    logic        r_vsyncD1;
    logic        r_vsyncD2;
    logic [3:0]  r_hdrIdx;
    logic [31:0] r_pairCnt;
    logic        r_frameDone;
    logic        r_overflow;
    logic        r_frameErr;
    logic        w_vsyncRise;
    logic        w_capture;
    logic        w_clear;
    logic        w_pop;
    logic        w_valid;
    logic        w_dataLast;
    logic        w_fifoFull;
    logic        w_fifoEmpty;
    logic [47:0] w_fifoData;
    logic [47:0] w_pixelPair;
    logic [47:0] w_outData;

    assign w_vsyncRise = r_vsyncD1 && !r_vsyncD2;
    assign w_pixelPair = {D_R1, D_G1, D_B1, D_R0, D_G0, D_B0};
    assign w_capture   = HSYNC && (r_state != ST_IDLE);
    assign w_clear     = (r_state == ST_IDLE) && w_vsyncRise;

    sync_fifo #(
        .WIDTH (48),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_clear (w_clear),
        .i_push  (w_capture),
        .i_data  (w_pixelPair),
        .i_pop   (w_pop),
        .o_data  (w_fifoData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_valid     = 1'b0;
        w_outData   = '0;
        w_dataLast  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vsyncRise) w_nextState = ST_HDR;
            end
            ST_HDR: begin
                w_valid   = 1'b1;
                w_outData = bmp_header_word(int'(r_hdrIdx), WIDTH, HEIGHT);
                if (out_ready && r_hdrIdx == 4'(HDR_WORDS - 1)) w_nextState = ST_DATA;
            end
            ST_DATA: begin
                w_valid    = !w_fifoEmpty;
                w_outData  = w_valid ? w_fifoData : '0;
                w_dataLast = w_valid && (r_pairCnt == TOTAL_PAIRS - 1);
                w_pop      = w_valid && out_ready;
                if (w_pop && w_dataLast) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // VSYNC is registered before edge detection, so the header starts one cycle after the rise is sampled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_vsyncD1   <= 1'b0;
            r_vsyncD2   <= 1'b0;
            r_hdrIdx    <= '0;
            r_pairCnt   <= '0;
            r_frameDone <= 1'b0;
            r_overflow  <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_vsyncD1   <= VSYNC;
            r_vsyncD2   <= r_vsyncD1;
            r_frameDone <= w_pop && w_dataLast;
            if (w_clear) begin
                r_hdrIdx  <= '0;
                r_pairCnt <= '0;
            end else begin
                if (r_state == ST_HDR && out_ready) r_hdrIdx <= r_hdrIdx + 4'd1;
                if (w_pop) r_pairCnt <= r_pairCnt + 32'd1;
            end
            if (w_capture && w_fifoFull && !w_pop) r_overflow <= 1'b1;
            if (w_vsyncRise && r_state != ST_IDLE) r_frameErr <= 1'b1;
        end
    end

    assign out_data   = w_outData;
    assign out_valid  = w_valid;
    assign out_last   = w_dataLast;
    assign frame_done = r_frameDone;
    assign overflow   = r_overflow;
    assign frame_err  = r_frameErr;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Self-checking bench for bmp_stream_writer: a small 8x4 instance checked word by
// word against a byte-level golden BMP, plus a default-size instance for header constants.
module tb_bmp_stream_writer;

    localparam int TW          = 8;
    localparam int TH          = 4;
    localparam int TD          = 16;
    localparam int NPAIRS      = TW * TH / 2;
    localparam int TOTAL_WORDS = 9 + NPAIRS;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        VSYNC;
    logic        HSYNC;
    logic [7:0]  dR0, dG0, dB0, dR1, dG1, dB1;
    logic        out_ready;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        frame_done;
    logic        overflow;
    logic        frame_err;

    logic        dReady = 1'b1;
    logic [47:0] dData;
    logic        dValid, dLast, dDone, dOvf, dErr;
    logic [47:0] dWords [9];
    int          dCnt = 0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  gold [$];
    int          wordsDone;
    int          pairsSent;
    bit          prevStall;
    logic [47:0] prevData;
    logic        prevLast;
    bit          pendingDone;
    bit          doneLow;
    logic [47:0] firstData;

    bmp_stream_writer #(.WIDTH(TW), .HEIGHT(TH), .FIFO_DEPTH(TD)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .D_R0(dR0), .D_G0(dG0), .D_B0(dB0), .D_R1(dR1), .D_G1(dG1), .D_B1(dB1),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done), .overflow(overflow),
        .frame_err(frame_err)
    );

    bmp_stream_writer dutDefault (
        .HRESETn(HRESETn), .HCLK(HCLK), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .D_R0(dR0), .D_G0(dG0), .D_B0(dB0), .D_R1(dR1), .D_G1(dG1), .D_B1(dB1),
        .out_data(dData), .out_valid(dValid), .out_ready(dReady),
        .out_last(dLast), .frame_done(dDone), .overflow(dOvf), .frame_err(dErr)
    );

    always #5 HCLK = ~HCLK;

    // The default-size instance always accepts, so every valid word seen here transfers
    always @(negedge HCLK) begin
        if (HRESETn && dValid && dCnt < 9) begin
            dWords[dCnt] = dData;
            dCnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, {47'd0, obs}, {47'd0, exp});
    endtask

    task automatic putLe(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) gold.push_back(v[8*i +: 8]);
    endtask

    // Golden file image: header fields written byte by byte from the BMP layout
    task automatic buildHeader();
        gold.delete();
        gold.push_back(8'h42);
        gold.push_back(8'h4D);
        putLe(32'(54 + TW * TH * 3), 4);
        putLe(32'd0, 4);
        putLe(32'd54, 4);
        putLe(32'd40, 4);
        putLe(32'(TW), 4);
        putLe(-32'(TH), 4);
        putLe(32'd1, 2);
        putLe(32'd24, 2);
        putLe(32'd0, 4);
        putLe(32'(TW * TH * 3), 4);
        putLe(32'd2835, 4);
        putLe(32'd2835, 4);
        putLe(32'd0, 4);
        putLe(32'd0, 4);
    endtask

    function automatic logic [47:0] wordAt(input int idx);
        logic [47:0] w;
        if (gold.size() < 6 * idx + 6) return 48'hBAD0_BAD0_BAD0;
        for (int k = 0; k < 6; k++) w[8*k +: 8] = gold[6*idx + k];
        return w;
    endfunction

    task automatic sendPair(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                            input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1,
                            input bit record);
        dR0 = r0; dG0 = g0; dB0 = b0; dR1 = r1; dG1 = g1; dB1 = b1;
        HSYNC = 1'b1;
        if (record) begin
            gold.push_back(b0); gold.push_back(g0); gold.push_back(r0);
            gold.push_back(b1); gold.push_back(g1); gold.push_back(r1);
            pairsSent++;
        end
    endtask

    task automatic sendRandom(input bit record);
        sendPair(8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), record);
    endtask

    // VSYNC rise sampled at edge k: header word 0 must appear after edge k+1, not earlier
    task automatic startFrame();
        buildHeader();
        wordsDone = 0; pairsSent = 0; prevStall = 0; pendingDone = 0; doneLow = 0;
        @(negedge HCLK);
        out_ready = 1'b0; HSYNC = 1'b0; VSYNC = 1'b1;
        @(negedge HCLK);
        checkBit("vsync_latency_k", out_valid, 1'b0);
        VSYNC = 1'b0;
        @(negedge HCLK);
        checkBit("vsync_latency_k1", out_valid, 1'b1);
        checkOutput("header_word0", out_data, wordAt(0));
    endtask

    task automatic applyStimulus(input int readyPct, input int pushPct, input int stopWords,
                                 input int vsyncAt, input bit fixFirst);
        int  cyc;
        bit  vsFired;
        vsFired = 0;
        for (cyc = 0; cyc < 1000; cyc++) begin
            @(negedge HCLK);
            if (pendingDone) begin
                checkBit("frame_done_pulse", frame_done, 1'b1);
                pendingDone = 0;
                doneLow = 1;
            end else if (doneLow) begin
                checkBit("frame_done_single", frame_done, 1'b0);
                doneLow = 0;
            end
            if (prevStall) begin
                checkBit("stall_valid", out_valid, 1'b1);
                checkOutput("stall_data", out_data, prevData);
                checkBit("stall_last", out_last, prevLast);
            end
            if (wordsDone >= stopWords && !pendingDone && !doneLow) break;
            VSYNC = 1'b0;
            if (vsyncAt >= 0 && !vsFired && wordsDone >= vsyncAt) begin
                VSYNC = 1'b1;
                vsFired = 1;
            end
            out_ready = (int'($urandom_range(99)) < readyPct);
            if (pairsSent < NPAIRS && int'($urandom_range(99)) < pushPct) begin
                if (fixFirst && pairsSent == 0) sendPair(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b1);
                else sendRandom(1'b1);
            end else begin
                HSYNC = 1'b0;
            end
            if (out_valid && out_ready) begin
                checkOutput("word", out_data, wordAt(wordsDone));
                checkBit("last_flag", out_last, wordsDone == TOTAL_WORDS - 1);
                if (wordsDone == 9) firstData = out_data;
                if (wordsDone == TOTAL_WORDS - 1) pendingDone = 1;
                wordsDone++;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
        end
        if (cyc >= 1000) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout words=%0d required=%0d", wordsDone, stopWords);
        end
        HSYNC = 1'b0;
        VSYNC = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0; out_ready = 1'b0;
        dR0 = '0; dG0 = '0; dB0 = '0; dR1 = '0; dG1 = '0; dB1 = '0;
        repeat (3) @(negedge HCLK);
        checkOutput("reset_data", out_data, 48'd0);
        checkBit("reset_valid", out_valid, 1'b0);
        checkBit("reset_last", out_last, 1'b0);
        checkBit("reset_done", frame_done, 1'b0);
        checkBit("reset_overflow", overflow, 1'b0);
        checkBit("reset_frame_err", frame_err, 1'b0);
        HRESETn = 1'b1;

        // Pixel pairs while idle must be discarded
        for (int i = 0; i < 5; i++) begin
            sendRandom(1'b0);
            @(negedge HCLK);
            checkBit("idle_no_output", out_valid, 1'b0);
        end
        HSYNC = 1'b0;

        // Frame 1: random stalls, first pair fixed
        startFrame();
        applyStimulus(50, 60, TOTAL_WORDS, -1, 1'b1);
        checkOutput("first_pair_word", firstData, 48'h4455_6611_2233);
        checkBit("f1_overflow", overflow, 1'b0);
        checkBit("f1_frame_err", frame_err, 1'b0);
        checkOutput("dflt_hdr_count", 48'(dCnt), 48'd9);
        checkOutput("dflt_hdr_word0", dWords[0], 48'h0012_0036_4D42);
        checkOutput("dflt_hdr_word1", dWords[1], 48'h0036_0000_0000);
        checkOutput("dflt_hdr_word3", dWords[3], 48'hFE00_0000_0300);
        checkOutput("dflt_hdr_word4", dWords[4], 48'h0018_0001_FFFF);

        // Frame 2: VSYNC mid-DATA is flagged and ignored
        startFrame();
        applyStimulus(50, 60, TOTAL_WORDS, 12, 1'b0);
        checkBit("f2_frame_err", frame_err, 1'b1);
        checkBit("f2_overflow", overflow, 1'b0);

        // Frame 3: stall after the header until one pair more than the FIFO holds arrives
        startFrame();
        applyStimulus(100, 0, 9, -1, 1'b0);
        out_ready = 1'b0;
        for (int i = 1; i <= TD + 1; i++) begin
            sendRandom(i <= TD);
            @(negedge HCLK);
            if (i == TD) checkBit("overflow_at_depth", overflow, 1'b0);
            if (i == TD + 1) checkBit("overflow_after_drop", overflow, 1'b1);
        end
        HSYNC = 1'b0;
        checkBit("overflow_head_valid", out_valid, 1'b1);
        checkOutput("overflow_head_word", out_data, wordAt(9));
        applyStimulus(100, 0, TOTAL_WORDS, -1, 1'b0);

        // Frame 4: reset mid-DATA aborts everything, including sticky flags
        startFrame();
        applyStimulus(70, 80, 14, -1, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("abort_data", out_data, 48'd0);
        checkBit("abort_valid", out_valid, 1'b0);
        checkBit("abort_last", out_last, 1'b0);
        checkBit("abort_done", frame_done, 1'b0);
        checkBit("abort_overflow", overflow, 1'b0);
        checkBit("abort_frame_err", frame_err, 1'b0);
        HSYNC = 1'b0; VSYNC = 1'b0; out_ready = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checkBit("post_reset_idle", out_valid, 1'b0);
        end

        // Frame 5: clean restart from header word 0
        startFrame();
        applyStimulus(50, 60, TOTAL_WORDS, -1, 1'b0);
        checkBit("f5_frame_err", frame_err, 1'b0);
        checkBit("f5_overflow", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
